// File: rtl/mem_port.sv
// mem_port: 2^DEPTH_LOG2 x 32-bit data memory behind a fixed-latency request/response handshake.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned or illegal-size accesses instead of force-aligning them.
module mem_port #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  func3,
  output logic [31:0] rdata,
  output logic        MemReady,
  output logic        MemError
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_func3;
  logic                  r_wr;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_misalign;
  logic                  w_req_err;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_sh;
  logic                  w_we;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [DEPTH_LOG2-1:0] w_wr_idx;
  logic [31:0]           w_word;
  logic [31:0]           w_shifted;
  logic [31:0]           w_load;
  logic                  w_unused_addr;

  assign w_accept      = (r_state == IDLE) && (MemoryRead || MemoryWrite);
  assign w_unused_addr = ^addr[31:DEPTH_LOG2+2];

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    w_misalign = 1'b0;
    case (func3)
      3'b001, 3'b101:         w_misalign = addr[0];
      3'b010:                 w_misalign = |addr[1:0];
      3'b011, 3'b110, 3'b111: w_misalign = 1'b1;
      default:                w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = (MemoryRead && MemoryWrite) || w_misalign;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (r_cnt == LAST_CNT) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == WAIT && w_state_next == WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= '0;
      end
      if (w_accept) begin
        r_wr  <= MemoryWrite;
        r_err <= w_req_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !clr) begin
      r_addr  <= addr[DEPTH_LOG2+1:0];
      r_wdata <= wdata;
      r_func3 <= func3;
    end
  end

  // Byte offset is force-aligned for H/W; in trap mode misaligned requests never write anyway.
  always_comb begin
    w_off = 2'b00;
    case (r_func3[1:0])
      2'b00:   w_off = r_addr[1:0];
      2'b01:   w_off = {r_addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end

  always_comb begin
    w_be = 4'b1111;
    case (r_func3[1:0])
      2'b00:   w_be = 4'b0001 << w_off;
      2'b01:   w_be = 4'b0011 << w_off;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_wdata_sh = r_wdata << {w_off, 3'b000};
  assign w_we       = (r_state == RESP) && r_wr && !r_err && !clr;
  assign w_wr_idx   = r_addr[DEPTH_LOG2+1:2];
  // Read every cycle; the edge entering RESP uses the live address when there are no wait states.
  assign w_rd_idx   = (r_state == IDLE) ? addr[DEPTH_LOG2+1:2] : r_addr[DEPTH_LOG2+1:2];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_bank [0:DEPTH-1];
      logic [7:0] r_rd_byte;

      always_ff @(posedge clk) begin
        if (w_we && w_be[gi]) begin
          r_bank[w_wr_idx] <= w_wdata_sh[8*gi +: 8];
        end
        r_rd_byte <= r_bank[w_rd_idx];
      end

      assign w_word[8*gi +: 8] = r_rd_byte;
    end
  endgenerate

  assign w_shifted = w_word >> {w_off, 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (r_func3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load = {24'd0, w_shifted[7:0]};
      3'b101:  w_load = {16'd0, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  assign MemReady = (r_state == RESP);
  assign MemError = (r_state == RESP) && r_err;
  assign rdata    = ((r_state == RESP) && !r_err) ? w_load : 32'd0;

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, word-address width of internal storage (2^DEPTH_LOG2 x 32-bit words).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states between request acceptance and response, range 0..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 MemoryRead  input  1  read request strobe from the control unit.
REQ-006 MemoryWrite  input  1  write request strobe from the control unit.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0]).
REQ-009 func3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 rdata  output  32  load data, extended per func3, valid only while MemReady=1.
REQ-011 MemReady  output  1  one-cycle response pulse; request complete.
REQ-012 MemError  output  1  qualifies MemReady; access faulted.

Function
REQ-013 FSM states IDLE, WAIT, RESP; IDLE->WAIT on accept when WAIT_CYCLES>0, IDLE->RESP on accept when WAIT_CYCLES=0, WAIT->RESP when wait counter reaches WAIT_CYCLES-1, RESP->IDLE unconditionally.
REQ-014 Request accepted only in IDLE when MemoryRead or MemoryWrite is 1; addr, wdata, func3 and direction latched on that edge.
REQ-015 Strobes and inputs while in WAIT or RESP are ignored; no queuing.
REQ-016 Total latency: MemReady asserts exactly WAIT_CYCLES+1 cycles after the accepting edge; minimum back-to-back request spacing WAIT_CYCLES+2 cycles.
REQ-017 MemReady is high for exactly one cycle, in RESP only.
REQ-018 Word index = latched addr[DEPTH_LOG2+1:2]; higher address bits ignored (aliasing wrap-around, no error).
REQ-019 Store commits in the RESP cycle, byte lanes selected by addr[1:0] and size; unselected bytes unchanged.
REQ-020 Load: selected byte/half shifted to LSB; func3 000/001 sign-extend, 100/101 zero-extend, 010 full word.
REQ-021 Read data reflects storage contents at RESP, including a store committed in the previous RESP.
REQ-022 MemoryRead and MemoryWrite both high at accept: no storage write, response MemReady=1, MemError=1, rdata=0.
REQ-023 rdata = 0 whenever MemReady = 0 or MemError = 1.
REQ-024 A store to the same word as a following load returns the new data (no stale read).

Reset
REQ-025 clr=1 on an edge forces state IDLE, wait counter 0, MemReady=0, MemError=0, rdata=0; takes priority over all requests.
REQ-026 clr asserted during WAIT or RESP aborts the request: no store commits, no MemReady pulse.
REQ-027 Storage contents are not cleared by clr; contents after power-up are undefined.

Configuration
REQ-028 Macro MEM_MISALIGN_TRAP_EN defined: halfword with addr[0]=1, word with addr[1:0]!=00, or func3 in {011,110,111} responds MemError=1, no store, rdata=0.
REQ-029 MEM_MISALIGN_TRAP_EN undefined: misaligned accesses force-aligned (addr[0] cleared for H/HU, addr[1:0] cleared for W), func3 011/110/111 treated as W, MemError asserts only per REQ-022.

Verification
REQ-030 WAIT_CYCLES=2: SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> each MemReady exactly 3 cycles after accept, rdata 0xDEADBEEF, MemError=0.
REQ-031 Word 0x20 = 0x11223344; SB addr 0x21 wdata 0xAA; LW 0x20 -> 0x1122AA44; LB 0x21 -> 0xFFFFFFAA; LBU 0x21 -> 0x000000AA.
REQ-032 SH addr 0x32 wdata 0x8001; LH 0x32 -> 0xFFFF8001; LHU 0x32 -> 0x00008001.
REQ-033 With MEM_MISALIGN_TRAP_EN: LW addr 0x13 -> MemReady=1, MemError=1, rdata=0; SH addr 0x41 -> MemError=1, word 0x40 unchanged; without macro, LW 0x13 returns word at 0x10, MemError=0.
REQ-034 SW 0x08 accepted, clr pulsed during WAIT -> no MemReady, LW 0x08 returns prior contents; MemoryRead and MemoryWrite both high -> MemError=1, no write.
REQ-035 DEPTH_LOG2=10: SW addr 0x1000 wdata 0x5A5A5A5A, LW addr 0x0 -> 0x5A5A5A5A (wrap); second MemoryRead held high through WAIT -> exactly one MemReady pulse.
